pipe_ctrl_unit: RTL and testbench
=================================

PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-index width.
REQ-002 SHALL have parameter ENABLE_JUMP, default 1, decode JAL/JALR when 1, treat them as illegal when 0.
REQ-003 SHALL have parameter CNT_W, default 16, width of the stall and flush event counters.
REQ-004 SHALL have one clock and an asynchronous, active-high reset:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have the following ports:
- opcode  in  7  ID-stage instruction opcode.
- id_valid  in  1  ID-stage instruction is valid.
- rs1, rs2, rd  in  REG_ADDR_W each  ID-stage register indices.
- branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- hold  in  1  global freeze of all stage registers.
- stall  out  1  load-use stall request to PC and IF/ID.
- flush  out  1  equals branch_taken & ~hold.
- illegal  out  1  valid ID opcode not decodable.
- ex_branch, ex_jump, ex_memread, ex_memwrite, ex_memtoreg, ex_aluSrc, ex_regwrite  out  1 each  ID/EX control.
- ex_AlUop  out  2  ID/EX ALU op class.
- ex_rd  out  REG_ADDR_W  ID/EX destination.
- mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite  out  1 each  EX/MEM control.
- mem_rd  out  REG_ADDR_W  EX/MEM destination.
- wb_memtoreg, wb_regwrite  out  1 each  MEM/WB control.
- wb_rd  out  REG_ADDR_W  MEM/WB destination.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Function
REQ-006 Decode (comb, ID) SHALL produce {aluSrc,memtoreg,regwrite,memread,memwrite,branch,jump,AlUop}:
- load 0000011 = 1,1,1,1,0,0,0,00.
- store 0100011 = 1,0,0,0,1,0,0,00.
- R-type 0110011 = 0,0,1,0,0,0,0,10.
- branch 1100011 = 0,0,0,0,0,1,0,01.
- I-ALU 0010011 = 1,0,1,0,0,0,0,00.
- JAL 1101111 = 0,0,1,0,0,0,1,00.
- JALR 1100111 = 1,0,1,0,0,0,1,00.
REQ-007 Undecodable opcode, or id_valid=0, SHALL decode to all-zero controls; illegal = id_valid & undecodable.
REQ-008 Decoded regwrite SHALL be forced 0 when rd==0.
REQ-009 rs2 is used only by R-type, store and branch.
REQ-010 stall (comb) SHALL equal id_valid & ex_memread & (ex_rd!=0) & ((ex_rd==rs1) | (rs2 used & ex_rd==rs2)) & ~branch_taken.
REQ-011 Each rising edge with hold=0 SHALL advance all stages: MEM/WB<=EX/MEM fields, EX/MEM<=ID/EX fields, ID/EX<=decode.
REQ-012 ID/EX SHALL load an all-zero bubble instead of decode when flush=1 or stall=1; flush has priority; EX/MEM and MEM/WB still advance.
REQ-013 hold=1 SHALL freeze all stage registers and counters; stall is still computed; flush is forced 0.
REQ-014 Latency ID->EX->MEM->WB SHALL be 1 cycle per stage; a decoded control appears on wb_* exactly 3 unheld edges after entering ID.
REQ-015 stall_cnt SHALL increment by 1 on each unheld edge with stall=1, and flush_cnt likewise with flush=1; both saturate at all-ones, no wrap.

Reset
REQ-016 reset=1 SHALL asynchronously clear all stage registers, ex_rd/mem_rd/wb_rd, and both counters to 0; all ex_/mem_/wb_ outputs read 0.
REQ-017 Reset asserted mid-stream SHALL discard all in-flight controls; the first unheld edge after release loads ID/EX from decode.

Verification
REQ-018 Apply R-type (rd=3), id_valid=1, no hold -> ex_regwrite=1 and ex_AlUop=10 after 1 edge; wb_regwrite=1, wb_rd=3 after 3 edges.
REQ-019 Load rd=5 in EX, ID R-type rs2=5 -> stall=1, ID/EX bubble next edge (ex_regwrite=0), stall_cnt=1; with rd=0 instead -> stall=0.
REQ-020 branch_taken=1 together with stall condition -> stall=0, flush=1, ID/EX bubble, flush_cnt increments, stall_cnt unchanged.
REQ-021 hold=1 for 4 cycles with pipeline full -> all ex_/mem_/wb_ outputs and counters unchanged; release -> resume advancing.
REQ-022 ENABLE_JUMP=0 with JAL, id_valid=1 -> illegal=1, all controls 0; ENABLE_JUMP=1 -> ex_jump=1, ex_regwrite=1.
REQ-023 CNT_W=2, stall held 5 unheld edges -> stall_cnt=3; assert reset async mid-cycle -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: ID-stage decode, load-use stall detection, branch
// flush, ID/EX -> EX/MEM -> MEM/WB control pipeline and saturating event counters.
module pipe_ctrl_unit #(
    parameter int REG_ADDR_W  = 5,
    parameter int ENABLE_JUMP = 1,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            opcode,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  branch_taken,
    input  logic                  hold,
    output logic                  stall,
    output logic                  flush,
    output logic                  illegal,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic                  ex_memread,
    output logic                  ex_memwrite,
    output logic                  ex_memtoreg,
    output logic                  ex_aluSrc,
    output logic                  ex_regwrite,
    output logic [1:0]            ex_AlUop,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_memread,
    output logic                  mem_memwrite,
    output logic                  mem_memtoreg,
    output logic                  mem_regwrite,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_memtoreg,
    output logic                  wb_regwrite,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    // Decoded bundle order: {aluSrc,memtoreg,regwrite,memread,memwrite,branch,jump,AlUop[1:0]}
    logic [8:0] dec;
    logic       legal;
    logic       rs2_used;
    logic       bubble;

    // Combinational ID decode; invalid or unknown opcodes yield all-zero controls
    always_comb begin
        dec   = 9'b0;
        legal = 1'b0;
        if (id_valid) begin
            case (opcode)
                OP_LOAD:  begin dec = 9'b1_1_1_1_0_0_0_00; legal = 1'b1; end
                OP_STORE: begin dec = 9'b1_0_0_0_1_0_0_00; legal = 1'b1; end
                OP_RTYPE: begin dec = 9'b0_0_1_0_0_0_0_10; legal = 1'b1; end
                OP_BR:    begin dec = 9'b0_0_0_0_0_1_0_01; legal = 1'b1; end
                OP_IALU:  begin dec = 9'b1_0_1_0_0_0_0_00; legal = 1'b1; end
                OP_JAL:   if (ENABLE_JUMP != 0) begin dec = 9'b0_0_1_0_0_0_1_00; legal = 1'b1; end
                OP_JALR:  if (ENABLE_JUMP != 0) begin dec = 9'b1_0_1_0_0_0_1_00; legal = 1'b1; end
                default:  begin dec = 9'b0; legal = 1'b0; end
            endcase
        end
        // Writes to x0 are never real writes, so they must not look like hazards downstream
        if (rd == '0) dec[6] = 1'b0;
    end

    // Hazard and flush detection; a taken branch kills the ID instruction so no stall is needed
    always_comb begin
        rs2_used = (opcode == OP_RTYPE) || (opcode == OP_STORE) || (opcode == OP_BR);
        illegal  = id_valid & ~legal;
        stall    = id_valid & ex_memread & (ex_rd != '0) &
                   ((ex_rd == rs1) | (rs2_used & (ex_rd == rs2))) & ~branch_taken;
        flush    = branch_taken & ~hold;
        bubble   = flush | stall;
    end

    // Stage registers: advance on every unheld edge, ID/EX takes a bubble on stall/flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {ex_aluSrc, ex_memtoreg, ex_regwrite, ex_memread,
             ex_memwrite, ex_branch, ex_jump, ex_AlUop} <= 9'b0;
            ex_rd        <= '0;
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            mem_memtoreg <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_rd       <= '0;
            wb_memtoreg  <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_rd        <= '0;
        end else if (!hold) begin
            wb_memtoreg  <= mem_memtoreg;
            wb_regwrite  <= mem_regwrite;
            wb_rd        <= mem_rd;
            mem_memread  <= ex_memread;
            mem_memwrite <= ex_memwrite;
            mem_memtoreg <= ex_memtoreg;
            mem_regwrite <= ex_regwrite;
            mem_rd       <= ex_rd;
            if (bubble) begin
                {ex_aluSrc, ex_memtoreg, ex_regwrite, ex_memread,
                 ex_memwrite, ex_branch, ex_jump, ex_AlUop} <= 9'b0;
                ex_rd <= '0;
            end else begin
                {ex_aluSrc, ex_memtoreg, ex_regwrite, ex_memread,
                 ex_memwrite, ex_branch, ex_jump, ex_AlUop} <= dec;
                ex_rd <= legal ? rd : '0;
            end
        end
    end

    // Saturating stall/flush event counters, frozen while held
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!hold) begin
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
            if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: directed scenarios plus randomized traffic checked
// against an instruction-level reference model; a second instance covers
// ENABLE_JUMP=0 and a 2-bit counter.
module tb_pipe_ctrl_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- main instance (defaults) ----------------
    logic       reset, id_valid, branch_taken, hold;
    logic [6:0] opcode;
    logic [4:0] rs1, rs2, rd;
    logic       stall, flush, illegal;
    logic       ex_branch, ex_jump, ex_memread, ex_memwrite, ex_memtoreg, ex_aluSrc, ex_regwrite;
    logic [1:0] ex_AlUop;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic       mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite, wb_memtoreg, wb_regwrite;
    logic [15:0] stall_cnt, flush_cnt;

    pipe_ctrl_unit dut (
        .clk(clk), .reset(reset), .opcode(opcode), .id_valid(id_valid),
        .rs1(rs1), .rs2(rs2), .rd(rd), .branch_taken(branch_taken), .hold(hold),
        .stall(stall), .flush(flush), .illegal(illegal),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_aluSrc(ex_aluSrc),
        .ex_regwrite(ex_regwrite), .ex_AlUop(ex_AlUop), .ex_rd(ex_rd),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_memtoreg(mem_memtoreg),
        .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
        .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // ---------------- second instance: no jumps, 2-bit counters ----------------
    logic       b_reset, b_id_valid, b_branch_taken, b_hold;
    logic [6:0] b_opcode;
    logic [4:0] b_rs1, b_rs2, b_rd;
    logic       b_stall, b_flush, b_illegal;
    logic       b_ex_branch, b_ex_jump, b_ex_memread, b_ex_memwrite, b_ex_memtoreg, b_ex_aluSrc, b_ex_regwrite;
    logic [1:0] b_ex_AlUop;
    logic [4:0] b_ex_rd, b_mem_rd, b_wb_rd;
    logic       b_mem_memread, b_mem_memwrite, b_mem_memtoreg, b_mem_regwrite, b_wb_memtoreg, b_wb_regwrite;
    logic [1:0] b_stall_cnt, b_flush_cnt;

    pipe_ctrl_unit #(.REG_ADDR_W(5), .ENABLE_JUMP(0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(b_reset), .opcode(b_opcode), .id_valid(b_id_valid),
        .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd), .branch_taken(b_branch_taken), .hold(b_hold),
        .stall(b_stall), .flush(b_flush), .illegal(b_illegal),
        .ex_branch(b_ex_branch), .ex_jump(b_ex_jump), .ex_memread(b_ex_memread),
        .ex_memwrite(b_ex_memwrite), .ex_memtoreg(b_ex_memtoreg), .ex_aluSrc(b_ex_aluSrc),
        .ex_regwrite(b_ex_regwrite), .ex_AlUop(b_ex_AlUop), .ex_rd(b_ex_rd),
        .mem_memread(b_mem_memread), .mem_memwrite(b_mem_memwrite), .mem_memtoreg(b_mem_memtoreg),
        .mem_regwrite(b_mem_regwrite), .mem_rd(b_mem_rd),
        .wb_memtoreg(b_wb_memtoreg), .wb_regwrite(b_wb_regwrite), .wb_rd(b_wb_rd),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    // ---------------- reference model (instruction level) ----------------
    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYPE = 7'b0110011,
                           BR = 7'b1100011, IALU = 7'b0010011, JAL = 7'b1101111, JALR = 7'b1100111;

    typedef struct packed {
        logic branch, jump, memread, memwrite, memtoreg, alusrc, regwrite;
        logic [1:0] aluop;
        logic [4:0] rd;
    } ctl_t;

    // ex, mem, wb in flight
    ctl_t m_pipe [3];
    int   m_sc, m_fc;

    function automatic bit m_legal(logic [6:0] op, logic v);
        if (!v) return 0;
        return (op == LOAD) || (op == STORE) || (op == RTYPE) || (op == BR) ||
               (op == IALU) || (op == JAL) || (op == JALR);
    endfunction

    // Control meaning of each instruction class
    function automatic ctl_t m_dec(logic [6:0] op, logic v, logic [4:0] d);
        ctl_t c;
        c = '0;
        if (!m_legal(op, v)) return c;
        case (op)
            LOAD:  begin c.alusrc = 1; c.memtoreg = 1; c.regwrite = 1; c.memread = 1; end
            STORE: begin c.alusrc = 1; c.memwrite = 1; end
            RTYPE: begin c.regwrite = 1; c.aluop = 2'b10; end
            BR:    begin c.branch = 1; c.aluop = 2'b01; end
            IALU:  begin c.alusrc = 1; c.regwrite = 1; end
            JAL:   begin c.regwrite = 1; c.jump = 1; end
            default: begin c.alusrc = 1; c.regwrite = 1; c.jump = 1; end
        endcase
        if (d == 0) c.regwrite = 0;
        c.rd = d;
        return c;
    endfunction

    function automatic bit m_stall();
        bit uses2;
        uses2 = (opcode == RTYPE) || (opcode == STORE) || (opcode == BR);
        return id_valid && m_pipe[0].memread && m_pipe[0].rd != 0 &&
               (m_pipe[0].rd == rs1 || (uses2 && m_pipe[0].rd == rs2)) && !branch_taken;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] o_ex();
        return {ex_branch, ex_jump, ex_memread, ex_memwrite, ex_memtoreg, ex_aluSrc, ex_regwrite, ex_AlUop, ex_rd};
    endfunction
    function automatic logic [63:0] o_mem();
        return {mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite, mem_rd};
    endfunction
    function automatic logic [63:0] o_wb();
        return {wb_memtoreg, wb_regwrite, wb_rd};
    endfunction

    task automatic check_regs(input string tag);
        ctl_t e, m, w;
        e = m_pipe[0]; m = m_pipe[1]; w = m_pipe[2];
        chk({tag, ".ex"},  o_ex(),  {e.branch, e.jump, e.memread, e.memwrite, e.memtoreg, e.alusrc, e.regwrite, e.aluop, e.rd});
        chk({tag, ".mem"}, o_mem(), {m.memread, m.memwrite, m.memtoreg, m.regwrite, m.rd});
        chk({tag, ".wb"},  o_wb(),  {w.memtoreg, w.regwrite, w.rd});
        chk({tag, ".cnt"}, {stall_cnt, flush_cnt}, {m_sc[15:0], m_fc[15:0]});
    endtask

    // Check comb outputs, clock one edge, advance the model, check registers
    task automatic step(input string tag);
        bit s, f;
        #1;
        s = m_stall();
        f = branch_taken && !hold;
        chk({tag, ".comb"}, {stall, flush, illegal}, {s, f, id_valid && !m_legal(opcode, id_valid)});
        @(posedge clk);
        if (!hold) begin
            m_pipe[2] = m_pipe[1];
            m_pipe[1] = m_pipe[0];
            m_pipe[0] = (s || f) ? '0 : m_dec(opcode, id_valid, rd);
            if (s && m_sc < 65535) m_sc++;
            if (f && m_fc < 65535) m_fc++;
        end
        #1;
        check_regs(tag);
    endtask

    task automatic model_reset();
        foreach (m_pipe[i]) m_pipe[i] = '0;
        m_sc = 0;
        m_fc = 0;
    endtask

    task automatic set_id(input logic [6:0] op, input logic v, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
        opcode = op; id_valid = v; rs1 = a; rs2 = b; rd = d;
    endtask

    task automatic b_set(input logic [6:0] op, input logic v, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
        b_opcode = op; b_id_valid = v; b_rs1 = a; b_rs2 = b; b_rd = d;
    endtask

    logic [6:0] ops [9];
    int sc0, fc0;

    initial begin
        ops[0] = LOAD; ops[1] = STORE; ops[2] = RTYPE; ops[3] = BR; ops[4] = IALU;
        ops[5] = JAL;  ops[6] = JALR;  ops[7] = 7'b1111111; ops[8] = LOAD;

        reset = 1'b1; hold = 1'b0; branch_taken = 1'b0;
        set_id(7'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        b_reset = 1'b1; b_hold = 1'b0; b_branch_taken = 1'b0;
        b_set(7'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_regs("reset");
        reset = 1'b0; b_reset = 1'b0;

        // R-type through all stages
        set_id(RTYPE, 1'b1, 5'd1, 5'd2, 5'd3);
        step("rtype");
        chk("rtype.ex_regwrite", {ex_regwrite, ex_AlUop}, {1'b1, 2'b10});
        set_id(7'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        step("rtype.d1");
        step("rtype.d2");
        chk("rtype.wb", {wb_regwrite, wb_rd}, {1'b1, 5'd3});

        // Load-use stall on rs2
        set_id(LOAD, 1'b1, 5'd1, 5'd0, 5'd5);
        step("lu.load");
        set_id(RTYPE, 1'b1, 5'd4, 5'd5, 5'd6);
        #1 chk("lu.stall", stall, 1'b1);
        step("lu.bubble");
        chk("lu.after", {ex_regwrite, stall_cnt}, {1'b0, 16'd1});
        // Destination x0 never causes a stall
        set_id(LOAD, 1'b1, 5'd1, 5'd0, 5'd0);
        step("lu0.load");
        set_id(RTYPE, 1'b1, 5'd0, 5'd0, 5'd6);
        #1 chk("lu0.stall", stall, 1'b0);
        step("lu0.next");

        // Taken branch beats the stall
        set_id(LOAD, 1'b1, 5'd1, 5'd0, 5'd5);
        step("bt.load");
        sc0 = m_sc; fc0 = m_fc;
        set_id(RTYPE, 1'b1, 5'd5, 5'd2, 5'd7);
        branch_taken = 1'b1;
        #1 chk("bt.comb", {stall, flush}, 2'b01);
        step("bt.flush");
        branch_taken = 1'b0;
        chk("bt.cnt", {ex_regwrite, stall_cnt, flush_cnt}, {1'b0, sc0[15:0], fc0[15:0] + 16'd1});

        // Hold with a full pipeline
        set_id(IALU, 1'b1, 5'd1, 5'd0, 5'd8);  step("hf.1");
        set_id(STORE, 1'b1, 5'd1, 5'd2, 5'd0); step("hf.2");
        set_id(LOAD, 1'b1, 5'd3, 5'd0, 5'd9);  step("hf.3");
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_id(RTYPE, 1'b1, 5'd9, 5'd9, 5'(10 + i));
            branch_taken = (i == 2);
            step("hold");
        end
        hold = 1'b0; branch_taken = 1'b0;
        step("hold.release");
        step("hold.resume");

        // Jumps decoded when enabled
        set_id(JAL, 1'b1, 5'd0, 5'd0, 5'd1);
        step("jal");
        chk("jal.ex", {ex_jump, ex_regwrite}, 2'b11);

        // Randomized traffic with an occasional async reset
        for (int i = 0; i < 600; i++) begin
            set_id(($urandom_range(0, 9) == 9) ? 7'($urandom) : ops[$urandom_range(0, 8)],
                   $urandom_range(0, 9) != 0, 5'($urandom_range(0, 6)),
                   5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)));
            branch_taken = $urandom_range(0, 7) == 0;
            hold = $urandom_range(0, 9) == 0;
            if (i % 150 == 149) begin
                reset = 1'b1;
                #1;
                model_reset();
                check_regs("rnd.reset");
                reset = 1'b0;
            end
            step("rnd");
        end
        hold = 1'b0; branch_taken = 1'b0;

        // Second instance: jumps are illegal when disabled
        b_set(JAL, 1'b1, 5'd0, 5'd0, 5'd1);
        #1 chk("b.jal.illegal", b_illegal, 1'b1);
        @(posedge clk); #1;
        chk("b.jal.ex", {b_ex_jump, b_ex_regwrite, b_ex_aluSrc, b_ex_rd}, 8'd0);
        // Load chasing itself stalls every other edge; 5 stalls saturate a 2-bit counter
        b_set(LOAD, 1'b1, 5'd5, 5'd0, 5'd5);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        chk("b.sat", b_stall_cnt, 2'd3);
        @(posedge clk); #1;
        chk("b.sat.hold", {b_ex_memread, b_stall_cnt}, {1'b1, 2'd3});
        // Async reset takes effect before the next edge
        #2 b_reset = 1'b1;
        #1;
        chk("b.reset", {b_ex_memread, b_ex_memtoreg, b_ex_regwrite, b_ex_aluSrc, b_ex_rd,
                        b_mem_memread, b_mem_memtoreg, b_mem_regwrite, b_mem_rd,
                        b_wb_memtoreg, b_wb_regwrite, b_wb_rd, b_stall_cnt, b_flush_cnt}, 64'd0);
        b_reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
